// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Macro IFU_SUPERVISOR_BIT_EN (see pc_next_sel) changes how redirect targets treat pc[31].
package ifu_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INT_VECTOR_DEFAULT   = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR_DEFAULT   = 32'h8000_0008;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } ifuState_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_EXC,
        SEL_INT,
        SEL_JR,
        SEL_J,
        SEL_BR
    } redirSel_t;

    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Redirect priority mux (exc > int > jr > j > br) and target arithmetic.
// With IFU_SUPERVISOR_BIT_EN defined, pc[31] acts as the kernel-mode bit on every target.
module pc_next_sel
    import ifu_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR = INT_VECTOR_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic [31:0] pc,
    input  logic        redir_exc,
    input  logic        redir_int,
    input  logic        redir_jr,
    input  logic [31:0] jr_target,
    input  logic        redir_j,
    input  logic [25:0] j_addr,
    input  logic        redir_br,
    input  logic [31:0] br_pc4,
    input  logic [15:0] br_imm,
    output logic        redirValid,
    output logic [31:0] redirTarget
);

    redirSel_t   redirSel;
    logic [31:0] brTarget;
    logic [31:0] jTarget;
    logic [31:0] rawTarget;

    always_comb begin
        redirSel = SEL_NONE;
        if (redir_exc)      redirSel = SEL_EXC;
        else if (redir_int) redirSel = SEL_INT;
        else if (redir_jr)  redirSel = SEL_JR;
        else if (redir_j)   redirSel = SEL_J;
        else if (redir_br)  redirSel = SEL_BR;
    end

    always_comb begin
        brTarget  = br_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
        jTarget   = ((pc + 32'd4) & 32'hF000_0000) | {4'b0000, j_addr, 2'b00};
        rawTarget = '0;
        case (redirSel)
            SEL_EXC: rawTarget = EXC_VECTOR;
            SEL_INT: rawTarget = INT_VECTOR;
            SEL_JR:  rawTarget = jr_target;
            SEL_J:   rawTarget = jTarget;
            SEL_BR:  rawTarget = brTarget;
            default: rawTarget = '0;
        endcase
`ifdef IFU_SUPERVISOR_BIT_EN
        // jr may drop out of kernel mode but can never raise the bit itself
        case (redirSel)
            SEL_EXC, SEL_INT: rawTarget[31] = 1'b1;
            SEL_JR:           rawTarget[31] = jr_target[31] & pc[31];
            SEL_J, SEL_BR:    rawTarget[31] = pc[31];
            default:          rawTarget[31] = rawTarget[31];
        endcase
`endif
        redirTarget = wordAlign(rawTarget);
    end

    assign redirValid = (redirSel != SEL_NONE);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from variable-latency imem and feeds IF/ID.
// Optional IFU_SUPERVISOR_BIT_EN is handled inside pc_next_sel.
//
//   state | meaning
//   REQ   | imem_req driven for one cycle at pc (idle one cycle after reset)
//   WAIT  | request outstanding, waiting for imem_ready
//   HOLD  | instruction presented on o_*, waiting for ID to consume
//   DRAIN | fetch aborted by redirect, discarding its response
module inst_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] INT_VECTOR   = INT_VECTOR_DEFAULT,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redir_exc,
    input  logic        redir_int,
    input  logic        redir_jr,
    input  logic [31:0] jr_target,
    input  logic        redir_j,
    input  logic [25:0] j_addr,
    input  logic        redir_br,
    input  logic [31:0] br_pc4,
    input  logic [15:0] br_imm,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        o_valid,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc_plus_4
);

    ifuState_t   state;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        redirValid;
    logic [31:0] redirTarget;

    pc_next_sel #(
        .INT_VECTOR (INT_VECTOR),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_pc_next_sel (
        .pc          (pc),
        .redir_exc   (redir_exc),
        .redir_int   (redir_int),
        .redir_jr    (redir_jr),
        .jr_target   (jr_target),
        .redir_j     (redir_j),
        .j_addr      (j_addr),
        .redir_br    (redir_br),
        .br_pc4      (br_pc4),
        .br_imm      (br_imm),
        .redirValid  (redirValid),
        .redirTarget (redirTarget)
    );

    assign pcPlus4   = pc + 32'd4;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= REQ;
            pc            <= wordAlign(RESET_VECTOR);
            imem_req      <= 1'b0;
            o_valid       <= 1'b0;
            o_instruction <= '0;
            o_pc_plus_4   <= 32'h8000_0000;
        end else begin
            case (state)
                REQ: begin
                    if (redirValid) pc <= redirTarget;
                    // imem_req low here only on the idle cycle after reset: nothing is outstanding
                    if (imem_req) begin
                        imem_req <= 1'b0;
                        state    <= redirValid ? DRAIN : WAIT;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                WAIT: begin
                    if (redirValid) begin
                        pc <= redirTarget;
                        if (imem_ready) begin
                            imem_req <= 1'b1;
                            state    <= REQ;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (imem_ready) begin
                        o_instruction <= imem_rdata;
                        o_pc_plus_4   <= pcPlus4;
                        o_valid       <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirValid) begin
                        pc       <= redirTarget;
                        o_valid  <= 1'b0;
                        imem_req <= 1'b1;
                        state    <= REQ;
                    end else if (!stall) begin
                        pc       <= wordAlign(pcPlus4);
                        o_valid  <= 1'b0;
                        imem_req <= 1'b1;
                        state    <= REQ;
                    end
                end
                DRAIN: begin
                    if (redirValid) pc <= redirTarget;
                    if (imem_ready) begin
                        imem_req <= 1'b1;
                        state    <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed scenarios followed by randomized stall/redirect traffic.
module tb_inst_fetch_unit;

    localparam logic [31:0] RV = 32'h8000_0000;
    localparam logic [31:0] IV = 32'h8000_0004;
    localparam logic [31:0] EV = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redir_exc = 1'b0;
    logic        redir_int = 1'b0;
    logic        redir_jr = 1'b0;
    logic [31:0] jr_target = '0;
    logic        redir_j = 1'b0;
    logic [25:0] j_addr = '0;
    logic        redir_br = 1'b0;
    logic [31:0] br_pc4 = '0;
    logic [15:0] br_imm = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        o_valid;
    logic [31:0] o_instruction;
    logic [31:0] o_pc_plus_4;

    int nChecks = 0;
    int nPass = 0;
    int consumed = 0;
    int fixedLat = 2;
    bit memEnable = 1'b1;

    // front = address of the next instruction the fetch stream must deliver
    logic [31:0] expQ[$];
    logic [31:0] expPc;

    inst_fetch_unit #(
        .RESET_VECTOR (RV),
        .INT_VECTOR   (IV),
        .EXC_VECTOR   (EV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redir_exc     (redir_exc),
        .redir_int     (redir_int),
        .redir_jr      (redir_jr),
        .jr_target     (jr_target),
        .redir_j       (redir_j),
        .j_addr        (j_addr),
        .redir_br      (redir_br),
        .br_pc4        (br_pc4),
        .br_imm        (br_imm),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .o_valid       (o_valid),
        .o_instruction (o_instruction),
        .o_pc_plus_4   (o_pc_plus_4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memFn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    function automatic void timeoutFail(input string name);
        nChecks++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endfunction

    // rd bits: [4]=exc [3]=int [2]=jr [1]=j [0]=br
    function automatic logic [31:0] modelTarget(input logic [31:0] cur, input logic [4:0] rd,
                                                input logic [31:0] jrT, input logic [25:0] ja,
                                                input logic [31:0] bp, input logic [15:0] bi);
        logic [31:0] t;
        int off;
        off = int'($signed(bi)) * 4;
        if (rd[4])      t = EV;
        else if (rd[3]) t = IV;
        else if (rd[2]) t = jrT;
        else if (rd[1]) t = ((cur + 32'd4) & 32'hF000_0000) + {4'h0, ja, 2'b00};
        else            t = bp + 32'(off);
`ifdef IFU_SUPERVISOR_BIT_EN
        if (rd[4] || rd[3]) t[31] = 1'b1;
        else if (rd[2])     t[31] = jrT[31] && cur[31];
        else                t[31] = cur[31];
`endif
        return t & ~32'h3;
    endfunction

    task automatic drive(input bit st, input logic [4:0] rd, input logic [31:0] jrT,
                         input logic [25:0] ja, input logic [31:0] bp, input logic [15:0] bi);
        @(posedge clk);
        #1;
        stall = st;
        {redir_exc, redir_int, redir_jr, redir_j, redir_br} = rd;
        jr_target = jrT;
        j_addr    = ja;
        br_pc4    = bp;
        br_imm    = bi;
        if (rd != 5'd0) begin
            expPc = modelTarget(expPc, rd, jrT, ja, bp, bi);
            expQ.delete();
            expQ.push_back(expPc);
        end else if (o_valid && !st) begin
            expPc = expPc + 32'd4;
            expQ.push_back(expPc);
        end
    endtask

    task automatic idle(input bit st);
        drive(st, 5'd0, '0, '0, '0, '0);
    endtask

    task automatic waitReq(input string name, input logic [31:0] expAddr);
        for (int i = 0; i < 30; i++) begin
            idle(1'b0);
            if (imem_req) begin
                check(name, imem_addr, expAddr);
                return;
            end
        end
        timeoutFail(name);
    endtask

    task automatic waitValid(input string name);
        for (int i = 0; i < 30; i++) begin
            idle(1'b1);
            if (o_valid) return;
        end
        timeoutFail(name);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        check({tag, "_valid"}, {31'd0, o_valid},  32'd0);
        check({tag, "_instr"}, o_instruction,     32'd0);
        check({tag, "_pc4"},   o_pc_plus_4,       32'h8000_0000);
        check({tag, "_addr"},  imem_addr,         RV);
    endtask

    // instruction memory: one outstanding request, response after 1..4 cycles
    initial begin
        logic [31:0] a;
        int lat;
        forever begin
            @(negedge clk);
            if (reset && memEnable && imem_req) begin
                a   = imem_addr;
                lat = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 4));
                repeat (lat) @(posedge clk);
                #1;
                if (reset && memEnable) begin
                    imem_ready = 1'b1;
                    imem_rdata = memFn(a);
                    @(posedge clk);
                    #1;
                    imem_ready = 1'b0;
                    imem_rdata = $urandom;
                end
            end
        end
    end

    // monitor: checks fetch addresses and every instruction presented to ID
    always @(negedge clk) begin
        if (reset && !(redir_exc || redir_int || redir_jr || redir_j || redir_br)) begin
            if (imem_req) begin
                if (expQ.size() == 0) timeoutFail("fetch_addr_no_expectation");
                else check("fetch_addr", imem_addr, expQ[0]);
            end
            if (o_valid) begin
                if (expQ.size() == 0) begin
                    timeoutFail("out_no_expectation");
                end else begin
                    check("out_pc4", o_pc_plus_4, expQ[0] + 32'd4);
                    check("out_instr", o_instruction, memFn(expQ[0]));
                    if (stall) begin
                        check("hold_no_req", {31'd0, imem_req}, 32'd0);
                    end else begin
                        void'(expQ.pop_front());
                        consumed++;
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] expC;
        logic [4:0] rd;
        bit st;

        expPc = RV;
        expQ.push_back(RV);
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");

        // release, fetch with 2-cycle memory latency
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("first_cycle_no_req", {31'd0, imem_req}, 32'd0);
        waitValid("t1_valid");
        check("t1_pc4", o_pc_plus_4, 32'h8000_0004);
        check("t1_instr", o_instruction, memFn(RV));

        // stall holds the instruction, then consume
        repeat (4) idle(1'b1);
        idle(1'b0);
        waitReq("t2_next_req", 32'h8000_0004);

        // branch back by 4 words while the fetch is outstanding
        drive(1'b0, 5'b00001, '0, '0, 32'h8000_0010, 16'hFFFC);
        waitReq("t3_br_req", 32'h8000_0000);

        // exception beats jump in the same cycle
        drive(1'b0, 5'b10010, '0, 26'h3FF_FFFF, '0, '0);
        waitReq("t4_exc_over_j", EV);

        // jr sequence (kernel bit behaviour depends on the build)
        drive(1'b0, 5'b00100, 32'h8000_0100, '0, '0, '0);
        waitReq("t5_jr_kernel", 32'h8000_0100);
        drive(1'b0, 5'b00100, 32'h0000_0040, '0, '0, '0);
        waitReq("t5_jr_leave", 32'h0000_0040);
        drive(1'b0, 5'b00100, 32'h8000_0000, '0, '0, '0);
`ifdef IFU_SUPERVISOR_BIT_EN
        expC = 32'h0000_0000;
`else
        expC = 32'h8000_0000;
`endif
        waitReq("t5_jr_no_enter", expC);

        // reset while a fetch is outstanding, with stray imem_ready pulses
        waitValid("t6_prep_valid");
        memEnable = 1'b0;
        idle(1'b0);
        for (int i = 0; i < 30; i++) begin
            idle(1'b0);
            if (imem_req) break;
        end
        idle(1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        stall = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        expQ.delete();
        expQ.push_back(RV);
        expPc = RV;
        #2;
        checkResetOutputs("t6_in_reset");
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hBAD0_0BAD;
        @(negedge clk);
        check("t6_no_req_after_reset", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        memEnable = 1'b1;
        fixedLat = 1;
        check("t6_restart_req", {31'd0, imem_req}, 32'd1);
        check("t6_restart_addr", imem_addr, RV);
        waitValid("t6_valid");
        check("t6_pc4", o_pc_plus_4, RV + 32'd4);
        check("t6_instr", o_instruction, memFn(RV));
        idle(1'b0);

        // randomized stalls, redirects and memory latency
        fixedLat = 0;
        consumed = 0;
        for (int c = 0; c < 1500; c++) begin
            st = ($urandom_range(0, 9) < 4);
            rd = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            drive(st, rd, $urandom, 26'($urandom), $urandom, 16'($urandom));
        end
        repeat (10) idle(1'b0);
        nChecks++;
        if (consumed >= 30) nPass++;
        else $display("FAIL random_throughput: consumed %0d, required at least 30", consumed);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
